// File: rtl/screen_sequencer_pkg.sv
// Shared state encoding, index-width helper and default geometry for the
// HUB75 refresh scheduler.
package screen_sequencer_pkg;

    localparam int DEF_ROWS       = 16;
    localparam int DEF_PLANES     = 8;
    localparam int DEF_BASE_TICKS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_SHOW
    } seq_state_t;

    // Row/plane index width; a single-entry dimension still gets one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/screen_sequencer_bcm_timer.sv
// Loadable down-counter timing one BCM output-enable window of
// BASE_TICKS << shift cycles; done is the terminal-count compare.
module bcm_timer
    import screen_sequencer_pkg::*;
#(
    parameter int CNT_W      = 13,
    parameter int SHIFT_W    = 3,
    parameter int BASE_TICKS = DEF_BASE_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] shift,
    output logic               done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_val;

    // Loading N-1 and exiting on zero gives a window of exactly N cycles.
    assign load_val = (CNT_W'(BASE_TICKS) << shift) - CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/screen_sequencer.sv
// HUB75 refresh scheduler: walks rows and bit-planes, sequencing cache fetch,
// row shift, latch and BCM-weighted output enable, and arbitrates frame memory.
//
// state    | meaning
// IDLE     | refresh stopped, indices at 0
// MEM_WAIT | waiting for the paint writer to release frame memory
// FETCH    | cache load of (row, plane) in flight
// SHIFT    | HUB75 row shift in flight
// LATCH    | row latch strobe
// SHOW     | output enable for the plane's BCM weight
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int PLANES     = DEF_PLANES,
    parameter int BASE_TICKS = DEF_BASE_TICKS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_ENABLE,
    output logic                        out_CACHE,
    input  logic                        in_PLANE_READY_MM,
    output logic                        out_HUB75_INIT,
    input  logic                        in_HUB75_DONE,
    output logic                        out_LATCH,
    output logic                        out_OE,
    output logic [idx_bits(ROWS)-1:0]   out_ROW,
    output logic [idx_bits(PLANES)-1:0] out_PLANE,
    input  logic                        in_PAINT_REQ,
    output logic                        out_PAINT_GNT,
    output logic                        out_FRAME_DONE
);

    localparam int ROW_BITS   = idx_bits(ROWS);
    localparam int PLANE_BITS = idx_bits(PLANES);
    localparam int CNT_W      = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

    seq_state_t            state_q, state_d;
    logic [ROW_BITS-1:0]   row_d;
    logic [PLANE_BITS-1:0] plane_d;
    logic                  cache_d, init_d, frame_d, gnt_d;
    logic                  tmr_start, tmr_done;
    logic                  last_row, last_plane;

    bcm_timer #(
        .CNT_W      (CNT_W),
        .SHIFT_W    (PLANE_BITS),
        .BASE_TICKS (BASE_TICKS)
    ) u_bcm_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tmr_start),
        .shift (out_PLANE),
        .done  (tmr_done)
    );

    assign last_row   = (out_ROW == ROW_BITS'(ROWS - 1));
    assign last_plane = (out_PLANE == PLANE_BITS'(PLANES - 1));

    always_comb begin
        state_d   = state_q;
        row_d     = out_ROW;
        plane_d   = out_PLANE;
        cache_d   = 1'b0;
        init_d    = 1'b0;
        frame_d   = 1'b0;
        tmr_start = 1'b0;
        // A held grant follows the request; a new grant only starts in IDLE/SHOW.
        gnt_d = out_PAINT_GNT ? in_PAINT_REQ
                              : (in_PAINT_REQ && (state_q == ST_IDLE || state_q == ST_SHOW));

        case (state_q)
            ST_IDLE: begin
                row_d   = '0;
                plane_d = '0;
                if (in_ENABLE) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!out_PAINT_GNT) begin
                    state_d = ST_FETCH;
                    cache_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (in_PLANE_READY_MM) begin
                    state_d = ST_SHIFT;
                    init_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (in_HUB75_DONE) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d   = ST_SHOW;
                tmr_start = 1'b1;
            end
            ST_SHOW: begin
                if (tmr_done) begin
                    if (last_plane) begin
                        plane_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            row_d = out_ROW + ROW_BITS'(1);
                        end
                    end else begin
                        plane_d = out_PLANE + PLANE_BITS'(1);
                    end
                    if (in_ENABLE) begin
                        state_d = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        plane_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            out_ROW        <= '0;
            out_PLANE      <= '0;
            out_CACHE      <= 1'b0;
            out_HUB75_INIT <= 1'b0;
            out_LATCH      <= 1'b0;
            out_OE         <= 1'b0;
            out_FRAME_DONE <= 1'b0;
            out_PAINT_GNT  <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_ROW        <= row_d;
            out_PLANE      <= plane_d;
            out_CACHE      <= cache_d;
            out_HUB75_INIT <= init_d;
            out_LATCH      <= (state_d == ST_LATCH);
            out_OE         <= (state_d == ST_SHOW);
            out_FRAME_DONE <= frame_d;
            out_PAINT_GNT  <= gnt_d;
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench: expected OE windows are queued at each cache request and
// checked when the window closes; a second fast instance covers frame wrap.
module tb_screen_sequencer;

    localparam int BASE      = 32;
    localparam int READY_DLY = 3;
    localparam int DONE_DLY  = 5;

    typedef struct {
        int row;
        int plane;
        int len;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, cache, ready, init, done, latch, oe, preq, gnt, fdone;
    logic [3:0] row;
    logic [2:0] plane;

    logic       rst_w, en_w, cache_w, ready_w, init_w, done_w, latch_w, oe_w;
    logic       preq_w, gnt_w, fdone_w;
    logic [3:0] row_w;
    logic [2:0] plane_w;

    int   total = 0;
    int   bad = 0;
    win_t sb[$];
    int   model_row = 0;
    int   model_plane = 0;
    int   cache_cnt = 0;
    int   windows_done = 0;
    int   last_row = 0;
    int   last_plane = 0;
    bit   wrap_finished = 1'b0;

    screen_sequencer u_dut (
        .clk               (clk),
        .rst               (rst),
        .in_ENABLE         (en),
        .out_CACHE         (cache),
        .in_PLANE_READY_MM (ready),
        .out_HUB75_INIT    (init),
        .in_HUB75_DONE     (done),
        .out_LATCH         (latch),
        .out_OE            (oe),
        .out_ROW           (row),
        .out_PLANE         (plane),
        .in_PAINT_REQ      (preq),
        .out_PAINT_GNT     (gnt),
        .out_FRAME_DONE    (fdone)
    );

    screen_sequencer #(.ROWS(16), .PLANES(8), .BASE_TICKS(1)) u_wrap (
        .clk               (clk),
        .rst               (rst_w),
        .in_ENABLE         (en_w),
        .out_CACHE         (cache_w),
        .in_PLANE_READY_MM (ready_w),
        .out_HUB75_INIT    (init_w),
        .in_HUB75_DONE     (done_w),
        .out_LATCH         (latch_w),
        .out_OE            (oe_w),
        .out_ROW           (row_w),
        .out_PLANE         (plane_w),
        .in_PAINT_REQ      (preq_w),
        .out_PAINT_GNT     (gnt_w),
        .out_FRAME_DONE    (fdone_w)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return oe;
            default: return init;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic lvl, input int lim, input string tag);
        int n;
        n = 0;
        while (sig_sel(which) !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sig_sel(which) !== lvl) check_val(tag, 0, 1);
    endtask

    task automatic wait_cache(input int n, input int lim);
        int k;
        k = 0;
        while (cache_cnt < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (cache_cnt < n) check_val("cache_timeout", cache_cnt, n);
    endtask

    // Cache/shift responder plus OE window monitor for the main instance.
    initial begin : responder
        int   ready_wait, done_wait, oe_len, win_row, win_plane;
        logic prev_ready, prev_done, prev_latch, prev_oe;
        win_t exp_w;
        ready = 1'b0; done = 1'b0;
        ready_wait = 0; done_wait = 0; oe_len = 0; win_row = 0; win_plane = 0;
        prev_ready = 1'b0; prev_done = 1'b0; prev_latch = 1'b0; prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                oe_len = 0;
                sb.delete();
                ready_wait = 0;
                done_wait = 0;
                ready = 1'b0;
                done = 1'b0;
            end else begin
                if (init) check_val("init_lat", prev_ready, 1);
                if (latch) begin
                    check_val("latch_lat", prev_done, 1);
                    check_val("latch_width", prev_latch, 0);
                    check_val("latch_oe", oe, 0);
                end
                if (oe && !prev_oe) begin
                    check_val("oe_after_latch", prev_latch, 1);
                    win_row = row;
                    win_plane = plane;
                end
                if (oe) begin
                    oe_len++;
                end else if (oe_len > 0) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", 0, 1);
                    end else begin
                        exp_w = sb.pop_front();
                        check_val("oe_len", oe_len, exp_w.len);
                        check_val("oe_row", win_row, exp_w.row);
                        check_val("oe_plane", win_plane, exp_w.plane);
                    end
                    windows_done++;
                    oe_len = 0;
                end
                ready = 1'b0;
                done = 1'b0;
                if (cache) begin
                    check_val("cache_row", row, model_row);
                    check_val("cache_plane", plane, model_plane);
                    sb.push_back('{model_row, model_plane, BASE << model_plane});
                    last_row = row;
                    last_plane = plane;
                    if (model_plane == 7) begin
                        model_plane = 0;
                        model_row = (model_row + 1) % 16;
                    end else begin
                        model_plane++;
                    end
                    cache_cnt++;
                    ready_wait = READY_DLY;
                end else if (ready_wait > 0) begin
                    ready_wait--;
                    if (ready_wait == 0) ready = 1'b1;
                end
                if (init) begin
                    done_wait = DONE_DLY;
                end else if (done_wait > 0) begin
                    done_wait--;
                    if (done_wait == 0) done = 1'b1;
                end
            end
            prev_ready = ready;
            prev_done = done;
            prev_latch = latch;
            prev_oe = oe;
        end
    end

    // Frame wrap on a fast instance whose ready/done are accepted on first cycle.
    initial begin : wrap_run
        int wcache, wfdone;
        wcache = 0; wfdone = 0;
        rst_w = 1'b1; en_w = 1'b0; ready_w = 1'b1; done_w = 1'b1; preq_w = 1'b0;
        #2 rst_w = 1'b0;
        repeat (3) @(negedge clk);
        rst_w = 1'b1;
        en_w = 1'b1;
        for (int cyc = 0; cyc < 20000 && wcache < 130; cyc++) begin
            @(negedge clk);
            if (cache_w) begin
                check_val("wrap_row", row_w, (wcache / 8) % 16);
                check_val("wrap_plane", plane_w, wcache % 8);
                wcache++;
            end
            if (fdone_w) begin
                wfdone++;
                check_val("wrap_steps", wcache, 128);
                check_val("wrap_idx", {row_w, plane_w}, 0);
            end
        end
        check_val("wrap_reached", wcache, 130);
        check_val("wrap_done_cnt", wfdone, 1);
        wrap_finished = 1'b1;
    end

    initial begin : main
        int c0, w0, viol, k;
        rst = 1'b1; en = 1'b0; preq = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("reset_outs", {cache, init, latch, oe, gnt, fdone, row, plane}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en = 1'b1;

        // Row 0 through all planes, then row 1 plane 0 is fetched.
        wait_cache(9, 12000);
        check_val("bcm_windows", windows_done, 8);

        // Paint request mid-SHOW, held well past the end of the window.
        wait_for(0, 1'b1, 100, "to_show_r1p0");
        repeat (10) @(negedge clk);
        check_val("gnt_pre_req", gnt, 0);
        preq = 1'b1;
        @(negedge clk);
        check_val("gnt_rise", gnt, 1);
        wait_for(0, 1'b0, 100, "show_end");
        c0 = cache_cnt;
        repeat (100) @(negedge clk);
        check_val("gnt_hold", gnt, 1);
        check_val("memwait_hold", cache_cnt, c0);
        preq = 1'b0;
        @(negedge clk);
        check_val("gnt_fall", gnt, 0);
        check_val("no_early_cache", cache, 0);
        @(negedge clk);
        check_val("cache_after_gnt", cache, 1);

        // Request raised during SHIFT: no grant until SHOW.
        wait_for(1, 1'b1, 50, "to_shift");
        preq = 1'b1;
        viol = 0;
        for (int i = 0; i < 50 && !oe; i++) begin
            @(negedge clk);
            if (gnt) viol++;
        end
        check_val("no_gnt_shift", viol, 0);
        @(negedge clk);
        check_val("gnt_in_show", gnt, 1);
        preq = 1'b0;

        // Disable during SHIFT: finish this plane, then IDLE.
        wait_for(1, 1'b1, 200, "to_shift2");
        en = 1'b0;
        wait_for(0, 1'b1, 50, "to_show_dis");
        wait_for(0, 1'b0, 300, "show_end_dis");
        c0 = cache_cnt;
        repeat (20) @(negedge clk);
        check_val("idle_row", row, 0);
        check_val("idle_plane", plane, 0);
        check_val("no_cache_idle", cache_cnt, c0);
        check_val("sb_empty", sb.size(), 0);
        model_row = 0;
        model_plane = 0;

        // Async reset mid-SHOW with the grant held.
        en = 1'b1;
        wait_cache(c0 + 1, 20);
        wait_for(0, 1'b1, 50, "to_show_rst");
        repeat (5) @(negedge clk);
        preq = 1'b1;
        repeat (2) @(negedge clk);
        check_val("gnt_pre_rst", gnt, 1);
        #2 rst = 1'b0;
        #1;
        check_val("oe_async", oe, 0);
        check_val("gnt_async", gnt, 0);
        preq = 1'b0;
        model_row = 0;
        model_plane = 0;
        c0 = cache_cnt;
        w0 = windows_done;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_cache(c0 + 1, 20);
        check_val("restart_row", last_row, 0);
        check_val("restart_plane", last_plane, 0);
        k = 0;
        while (windows_done <= w0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("restart_window", windows_done - w0, 1);

        k = 0;
        while (!wrap_finished && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_val("wrap_finished", wrap_finished, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Refresh scheduler for the HUB75 LED matrix path in SCREEN_CONTROL. It walks every row and bit-plane of the frame, and for each step it:
- asks the plane cache for data;
- starts the HUB75 shifter;
- latches the row;
- drives output-enable for a binary-weighted (BCM) time.

Between cache fetches it grants the shared frame-buffer memory to the paint writer.

## Interface
Parameters:
- ROWS, default 16: scan rows per frame; ROW_BITS = clog2(ROWS).
- PLANES, default 8: colour bit-planes; PLANE_BITS = clog2(PLANES).
- BASE_TICKS, default 32: OE-on cycles for plane 0. Plane p shows for BASE_TICKS << p cycles.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset, asynchronous, active-low.
- in_ENABLE  in  1  level; high = refresh runs continuously.
- out_CACHE  out  1  one-cycle pulse requesting a cache load of (out_ROW, out_PLANE).
- in_PLANE_READY_MM  in  1  cache load complete.
- out_HUB75_INIT  out  1  one-cycle pulse starting the HUB75 row shift.
- in_HUB75_DONE  in  1  shift complete.
- out_LATCH  out  1  one-cycle row latch strobe.
- out_OE  out  1  high = panel lit.
- out_ROW  out  ROW_BITS  current row address.
- out_PLANE  out  PLANE_BITS  current bit-plane.
- in_PAINT_REQ  in  1  paint writer requests frame-buffer memory (level).
- out_PAINT_GNT  out  1  memory granted to the paint writer.
- out_FRAME_DONE  out  1  one-cycle pulse after the last row/plane of a frame.

## Operation
States: IDLE, MEM_WAIT, FETCH, SHIFT, LATCH, SHOW.
- **IDLE**
  - Outputs are zero; row and plane are 0.
  - When in_ENABLE=1 → MEM_WAIT.
- **MEM_WAIT**
  - If out_PAINT_GNT=0 → FETCH, with out_CACHE pulsed on the transition cycle.
  - Otherwise stay until the grant drops.
- **FETCH**
  - Wait for in_PLANE_READY_MM.
  - When it arrives → SHIFT, with out_HUB75_INIT pulsed on the transition cycle.
- **SHIFT**
  - Wait for in_HUB75_DONE → LATCH.
- **LATCH**
  - out_LATCH=1 for one cycle; out_OE=0.
  - → SHOW, and load the show counter with (BASE_TICKS << plane) − 1.
- **SHOW**
  - out_OE=1 while the counter decrements.
  - When the counter reaches 0, advance the indices (see below), then:
    - in_ENABLE=1 → MEM_WAIT;
    - in_ENABLE=0 → IDLE, with indices cleared.

Index advance:
- Plane is the inner loop.
- When plane = PLANES−1: plane → 0 and row increments.
- When row = ROWS−1 and plane = PLANES−1: both wrap to 0 and out_FRAME_DONE pulses.

Paint arbitration:
- Grant is allowed only in IDLE and SHOW.
- out_PAINT_GNT rises the cycle after in_PAINT_REQ is seen high in an allowed state.
- Once granted, it is held until in_PAINT_REQ is seen low, and falls the next cycle, regardless of state.
- A grant never rises in MEM_WAIT, FETCH, SHIFT or LATCH.

## Timing
- Reset (async assert):
  - state = IDLE; row and plane = 0; show counter = 0.
  - Every output = 0, including out_OE and out_PAINT_GNT.
- Release is synchronous to clk.
- Reset mid-operation aborts immediately: OE drops asynchronously and the grant is revoked.
- All outputs are registered; no combinational input→output paths.
- Handshake sampling:
  - in_PLANE_READY_MM is sampled only in FETCH; in_HUB75_DONE only in SHIFT.
  - A pulse arriving in any other state is ignored and not remembered.
  - A ready/done asserted in the first cycle of FETCH/SHIFT is accepted.
- Latency:
  - MEM_WAIT→FETCH: 1 cycle when no grant is held.
  - READY seen → out_HUB75_INIT: 1 cycle.
  - DONE seen → out_LATCH: 1 cycle.
  - out_LATCH → out_OE high: 1 cycle.
  - out_OE stays high for exactly BASE_TICKS << plane cycles.
- Minimum gap between OE windows is 4 cycles.
- out_FRAME_DONE is asserted in the same cycle the indices wrap.
- in_ENABLE is sampled only in IDLE and at the end of SHOW; toggles elsewhere have no effect.
- Show counter width = clog2(BASE_TICKS << (PLANES−1)) + 1. It must not truncate at PLANES=8, BASE_TICKS=32, i.e. 4096 cycles.
- Simultaneous in_PAINT_REQ rise and SHOW expiry: the grant rises, and the FSM then holds in MEM_WAIT until the paint request drops.

## Structure
- A shared package holds:
  - the state encoding enum;
  - the ROW_BITS/PLANE_BITS derivation function;
  - the default ROWS, PLANES and BASE_TICKS constants.
- One sub-module, bcm_timer: loadable down-counter with a start input, a shift amount and a done flag, used for the SHOW window.
- The grant logic stays in the top module.

## Test plan
- **Single step.** Reset, in_ENABLE=1, READY 3 cycles after out_CACHE, DONE 5 cycles after out_HUB75_INIT.
  - out_LATCH one cycle, then out_OE high exactly 32 cycles for plane 0.
  - Then plane 1 is fetched.
- **BCM weighting.** PLANES=8, BASE_TICKS=32.
  - OE windows measure 32, 64, …, 4096 cycles.
  - Row increments after plane 7.
- **Frame wrap.** ROWS=16.
  - out_FRAME_DONE pulses once, after row 15 plane 7.
  - out_ROW/out_PLANE return to 0.
- **Paint arbitration.** in_PAINT_REQ raised mid-SHOW and held 100 cycles past SHOW end.
  - Grant rises 1 cycle after the request.
  - FSM waits in MEM_WAIT, and out_CACHE is pulsed 1 cycle after the grant falls.
  - Request during SHIFT: no grant until the next SHOW.
- **Disable.** in_ENABLE dropped during SHIFT.
  - Current plane completes its SHOW, then IDLE with indices at 0.
  - No further out_CACHE.
- **Async reset mid-SHOW with grant held.**
  - out_OE and out_PAINT_GNT go 0 without a clock edge.
  - After release, the sequence restarts at row 0, plane 0.
